// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns 32-bit fetches and 1/2/4-byte loads/stores
// into single-byte RAM/IO bus cycles, honouring bus pause, IO back-pressure and flush.
module mem_ctrl #(
  parameter int IO_SEL_HI = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        flush_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic        ls_signed,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, IFETCH = 2'd1, DREAD = 2'd2, DWRITE = 2'd3} state_t;

  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'b00:   size_to_len = 3'd1;
      2'b01:   size_to_len = 3'd2;
      default: size_to_len = 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] addr);
    is_io = (addr[IO_SEL_HI -: 2] == 2'b11);
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    put_byte = w;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] len,
                                              input logic sgn);
    case (len)
      3'd1:    load_extend = sgn ? {{24{word[7]}}, word[7:0]} : {24'd0, word[7:0]};
      3'd2:    load_extend = sgn ? {{16{word[15]}}, word[15:0]} : {16'd0, word[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  state_t      state_r, state_n;
  logic [2:0]  cnt_r, cnt_n;
  logic [2:0]  len_r, len_n;
  logic        signed_r, signed_n;
  logic [31:0] addr_r, addr_n;
  logic [31:0] wdata_r, wdata_n;
  logic [31:0] data_r, data_n;
  logic [31:0] mem_a_r, mem_a_n;
  logic [7:0]  mem_dout_r, mem_dout_n;
  logic        mem_wr_r, mem_wr_n;
  logic        if_done_r, if_done_n;
  logic        ls_done_r, ls_done_n;
  logic [31:0] if_data_r, if_data_n;
  logic [31:0] ls_rdata_r, ls_rdata_n;

  logic [31:0] rd_merge_s;
  logic [2:0]  wr_j_s;
  logic [31:0] wr_base_s, wr_word_s, wr_addr_s, wr_shift_s;
  logic        io_block_s;
  logic        done_busy_s;

  // Datapath helpers: read-byte merge and the next store byte to present
  always_comb begin
    rd_merge_s  = put_byte(data_r, cnt_r[1:0] - 2'd1, mem_din);
    done_busy_s = if_done_r | ls_done_r;
    if (state_r == IDLE) begin
      wr_j_s    = 3'd0;
      wr_base_s = ls_addr;
      wr_word_s = ls_wdata;
    end else begin
      // a byte counts as written only if it was on the bus while the CPU owned it
      wr_j_s    = (mem_wr_r && rdy_in) ? (cnt_r + 3'd1) : cnt_r;
      wr_base_s = addr_r;
      wr_word_s = wdata_r;
    end
    wr_addr_s  = wr_base_s + {29'd0, wr_j_s};
    wr_shift_s = wr_word_s >> {wr_j_s[1:0], 3'b000};
    io_block_s = is_io(wr_addr_s) && io_buffer_full;
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    len_n      = len_r;
    signed_n   = signed_r;
    addr_n     = addr_r;
    wdata_n    = wdata_r;
    data_n     = data_r;
    mem_a_n    = mem_a_r;
    mem_dout_n = mem_dout_r;
    mem_wr_n   = 1'b0;
    if_done_n  = 1'b0;
    ls_done_n  = 1'b0;
    if_data_n  = if_data_r;
    ls_rdata_n = ls_rdata_r;
    case (state_r)
      IDLE: begin
        mem_a_n = 32'd0;
        cnt_n   = 3'd0;
        if (rdy_in && !done_busy_s && !flush_in && ls_req) begin
          addr_n   = ls_addr;
          wdata_n  = ls_wdata;
          len_n    = size_to_len(ls_size);
          signed_n = ls_signed;
          data_n   = 32'd0;
          if (ls_we) begin
            state_n = DWRITE;
            if (io_block_s) begin
              mem_wr_n = 1'b0;
            end else begin
              mem_wr_n   = 1'b1;
              mem_a_n    = wr_addr_s;
              mem_dout_n = wr_shift_s[7:0];
            end
          end else begin
            state_n = DREAD;
            mem_a_n = ls_addr;
          end
        end else if (rdy_in && !done_busy_s && !flush_in && if_req) begin
          addr_n  = if_addr;
          len_n   = 3'd4;
          data_n  = 32'd0;
          state_n = IFETCH;
          mem_a_n = if_addr;
        end else begin
          state_n = IDLE;
        end
      end
      IFETCH, DREAD: begin
        if (!rdy_in) begin
          // bytes in flight are lost; restart the whole access on return
          cnt_n   = 3'd0;
          mem_a_n = addr_r;
        end else if (flush_in) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          mem_a_n = 32'd0;
        end else begin
          cnt_n = cnt_r + 3'd1;
          if (cnt_r != 3'd0) begin
            data_n = rd_merge_s;
          end else begin
            data_n = data_r;
          end
          if (cnt_r == len_r) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            mem_a_n = 32'd0;
            if (state_r == IFETCH) begin
              if_done_n = 1'b1;
              if_data_n = rd_merge_s;
            end else begin
              ls_done_n  = 1'b1;
              ls_rdata_n = load_extend(rd_merge_s, len_r, signed_r);
            end
          end else if ((cnt_r + 3'd1) < len_r) begin
            mem_a_n = addr_r + {29'd0, cnt_r} + 32'd1;
          end else begin
            mem_a_n = 32'd0;
          end
        end
      end
      DWRITE: begin
        if (!rdy_in) begin
          mem_a_n = 32'd0;
        end else begin
          cnt_n = wr_j_s;
          if (wr_j_s == len_r) begin
            state_n   = IDLE;
            cnt_n     = 3'd0;
            mem_a_n   = 32'd0;
            ls_done_n = 1'b1;
          end else if (io_block_s) begin
            mem_a_n = 32'd0;
          end else begin
            mem_wr_n   = 1'b1;
            mem_a_n    = wr_addr_s;
            mem_dout_n = wr_shift_s[7:0];
          end
        end
      end
      default: begin
        state_n = IDLE;
        mem_a_n = 32'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      len_r      <= 3'd0;
      signed_r   <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      data_r     <= 32'd0;
      mem_a_r    <= 32'd0;
      mem_dout_r <= 8'd0;
      mem_wr_r   <= 1'b0;
      if_done_r  <= 1'b0;
      ls_done_r  <= 1'b0;
      if_data_r  <= 32'd0;
      ls_rdata_r <= 32'd0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      len_r      <= len_n;
      signed_r   <= signed_n;
      addr_r     <= addr_n;
      wdata_r    <= wdata_n;
      data_r     <= data_n;
      mem_a_r    <= mem_a_n;
      mem_dout_r <= mem_dout_n;
      mem_wr_r   <= mem_wr_n;
      if_done_r  <= if_done_n;
      ls_done_r  <= ls_done_n;
      if_data_r  <= if_data_n;
      ls_rdata_r <= ls_rdata_n;
    end
  end

  assign mem_a    = mem_a_r;
  assign mem_dout = mem_dout_r;
  assign mem_wr   = mem_wr_r;
  assign if_done  = if_done_r;
  assign if_data  = if_data_r;
  assign ls_done  = ls_done_r;
  assign ls_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;
  logic        clk_in, rst_n_in, rdy_in;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full, flush_in;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_we, ls_signed, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int cyc, w0, seen;
  logic [7:0] ram [0:262143];

  mem_ctrl #(.IO_SEL_HI(17)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .flush_in(flush_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (mem_wr && rdy_in) begin
      ram[mem_a[17:0]] <= mem_dout;
      wr_cnt <= wr_cnt + 1;
    end
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] exp, input int lat);
    ls_req = 1'b1; ls_we = 1'b0; ls_size = sz; ls_signed = sgn; ls_addr = a;
    cyc = 0;
    do begin tick(); cyc++; end while (!ls_done && cyc < 40);
    ls_req = 1'b0;
    chk({tag, "_done"}, {31'd0, ls_done}, 32'd1);
    chk({tag, "_data"}, ls_rdata, exp);
    chk({tag, "_lat"}, cyc, lat);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_in = 1'b0;
    if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00;
    ls_signed = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
    ram[18'h200] = 8'h80; ram[18'h202] = 8'h01; ram[18'h203] = 8'h80;
    tick(); tick();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_dones", {30'd0, if_done, ls_done}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst_n_in = 1'b1;
    tick();

    // fetch: address sequence and done timing
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fetch_addr", mem_a, 32'h100 + k);
      chk("fetch_nowr", {31'd0, mem_wr}, 32'd0);
    end
    tick();
    chk("fetch_early", {31'd0, if_done}, 32'd0);
    tick();
    chk("fetch_done", {31'd0, if_done}, 32'd1);
    chk("fetch_data", if_data, 32'h00000513);
    if_req = 1'b0;
    tick();

    do_load("lb_s", 32'h200, 2'b00, 1'b1, 32'hFFFFFF80, 3);
    do_load("lb_u", 32'h200, 2'b00, 1'b0, 32'h00000080, 3);
    do_load("lh_s", 32'h202, 2'b01, 1'b1, 32'hFFFF8001, 4);

    // word store, byte by byte
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sw_wr", {31'd0, mem_wr}, 32'd1);
      chk("sw_addr", mem_a, 32'h300 + k);
      chk("sw_byte", {24'd0, mem_dout}, (32'h12345678 >> (8 * k)) & 32'hFF);
    end
    tick();
    chk("sw_done", {31'd0, ls_done}, 32'd1);
    chk("sw_wr_end", {31'd0, mem_wr}, 32'd0);
    ls_req = 1'b0;
    tick();
    do_load("lw_back", 32'h300, 2'b10, 1'b0, 32'h12345678, 6);

    // load beats fetch; fetch follows after a bubble
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h100;
    cyc = 0;
    do begin tick(); cyc++; end while (!ls_done && cyc < 40);
    chk("prio_ls_lat", cyc, 6);
    chk("prio_ls_data", ls_rdata, 32'h12345678);
    chk("prio_no_if", {31'd0, if_done}, 32'd0);
    ls_req = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (!if_done && cyc < 40);
    chk("prio_if_lat", cyc, 7);
    chk("prio_if_data", if_data, 32'h00000513);
    if_req = 1'b0;
    tick();

    // IO store held off by full buffer
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h00000041;
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("io_held", {31'd0, mem_wr}, 32'd0);
    end
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr", {31'd0, mem_wr}, 32'd1);
    chk("io_addr", mem_a, 32'h30000);
    chk("io_byte", {24'd0, mem_dout}, 32'h41);
    tick();
    chk("io_done", {31'd0, ls_done}, 32'd1);
    ls_req = 1'b0;
    tick();
    chk("io_wr_count", wr_cnt - w0, 32'd1);
    chk("io_ram", {24'd0, ram[18'h30000]}, 32'h41);

    // flush after two fetch bytes
    if_req = 1'b1; if_addr = 32'h100;
    tick(); tick();
    chk("fl_addr", mem_a, 32'h101);
    flush_in = 1'b1; if_req = 1'b0;
    tick();
    chk("fl_idle_a", mem_a, 32'd0);
    flush_in = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (if_done) seen++;
    end
    chk("fl_no_done", seen, 0);

    // flush in IDLE blocks acceptance
    flush_in = 1'b1; if_req = 1'b1;
    tick();
    chk("fl_idle_noacc", mem_a, 32'd0);
    flush_in = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (!if_done && cyc < 40);
    chk("fl_after_lat", cyc, 6);
    chk("fl_after_data", if_data, 32'h00000513);
    if_req = 1'b0;
    tick();

    // pause mid word load
    w0 = wr_cnt;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h300;
    tick(); tick();
    rdy_in = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (mem_wr || ls_done) seen++;
    end
    chk("pause_quiet", seen, 0);
    rdy_in = 1'b1;
    cyc = 5;
    do begin tick(); cyc++; end while (!ls_done && cyc < 40);
    ls_req = 1'b0;
    chk("pause_lat", cyc, 10);
    chk("pause_data", ls_rdata, 32'h12345678);
    chk("pause_no_wr", wr_cnt - w0, 32'd0);
    tick();

    // reset in the middle of a store
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h300; ls_wdata = 32'hAABBCCDD;
    tick(); tick();
    chk("rs_wr_before", {31'd0, mem_wr}, 32'd1);
    rst_n_in = 1'b0; ls_req = 1'b0;
    #1;
    chk("rs_wr_async", {31'd0, mem_wr}, 32'd0);
    chk("rs_a_async", mem_a, 32'd0);
    tick(); tick();
    rst_n_in = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (ls_done || mem_wr) seen++;
    end
    chk("rs_quiet", seen, 0);
    chk("rs_ram0", {24'd0, ram[18'h300]}, 32'hDD);
    chk("rs_ram1", {24'd0, ram[18'h301]}, 32'h56);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
